exec_unit_mc: RTL and testbench
===============================

Name: exec_unit_mc

Overview:
- Parametrised, pipelined successor to the single-cycle execute stage.
- Accepts one decoded operation per handshake and performs the ALU operation, branch/jump resolution and write-register select.
- Adds an iterative multi-cycle multiplier.
- Registers all results into an EX/MEM-facing output slot with valid/ready backpressure and flush.

Parameters:
- WIDTH, 16, datapath width; must be a power of two and at least 8.
- MUL_STEP, 1, multiplier bits retired per cycle; must divide WIDTH.
- REG_BITS, 3, width of register specifiers.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kill in-flight op and output slot.
- in_valid  in  1  upstream op available.
- in_ready  out  1  unit can accept this cycle.
- op  in  4  0 ADD, 1 SUB(a-b), 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 ROL, 7 MUL, 8 BEQZ, 9 BNEZ, 10 BLTZ, 11 BGEZ, 12 J, 13 JR, 14 SLT, 15 PASS.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second register operand.
- imm  in  WIDTH  pre-extended immediate.
- use_imm  in  1  second ALU operand is imm instead of b.
- pc_next  in  WIDTH  PC+2 of this op.
- wr_sel  in  2  write-register select: 00 rd0, 01 rd1, 10 rd2, 11 all-ones (link).
- rd0, rd1, rd2  in  REG_BITS each  candidate destination specifiers.
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  downstream consumes the slot this cycle.
- out_result  out  WIDTH  ALU/MUL result; pc_next for ops 8-13.
- out_wreg  out  REG_BITS  selected destination register.
- out_take_pc  out  1  redirect fetch.
- out_pc_target  out  WIDTH  redirect address.
- out_zero, out_neg  out  1 each  flags of out_result.
- busy  out  1  multiplier iterating.

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0, including out_valid, busy, out_take_pc, out_result and out_pc_target;
  - state IDLE, counter 0.
- Second operand: opB = use_imm ? imm : b.
- in_ready = (state==IDLE) & ~flush & (~out_valid | out_ready).
- An op is accepted on a rising edge where in_valid & in_ready.
- States:
  - IDLE: accepted non-MUL op → result registered at that edge; out_valid=1 the next cycle (latency 1). Accepted MUL → load multiplicand, multiplier and out_wreg; clear accumulator; go to MUL.
  - MUL: each cycle retires MUL_STEP multiplier bits (shift-add); busy=1. After WIDTH/MUL_STEP cycles in MUL → go to WAIT.
  - WAIT: if ~out_valid | out_ready → write the low WIDTH bits of the product to the slot, set out_valid=1, go to IDLE.
  - With WIDTH=16, MUL_STEP=1, an uncontested MUL is out_valid 17 cycles after acceptance.
- Arithmetic:
  - Wrap-around modulo 2^WIDTH; no carry or overflow outputs.
  - Shift and rotate amounts use opB[log2(WIDTH)-1:0].
  - SLT is signed; result is 1 or 0.
  - PASS outputs opB.
- Branches (8-11): test a as zero, non-zero, negative, or non-negative (signed).
  - out_take_pc = condition.
  - out_pc_target = pc_next+imm when taken, else pc_next.
- Jumps:
  - J: out_take_pc=1, target pc_next+imm.
  - JR: out_take_pc=1, target a+imm.
- Non-control ops: out_take_pc=0, out_pc_target=pc_next.
- out_zero / out_neg are computed from the registered out_result.
- Output slot:
  - Holds its value while out_valid & ~out_ready.
  - out_valid clears when out_ready is high and no new result is written that edge.
  - Simultaneous drain and new accept: the slot is overwritten, out_valid stays 1.
- flush (synchronous, highest priority):
  - At the edge: clears out_valid and out_take_pc; aborts MUL/WAIT → IDLE, busy=0.
  - No op is accepted in a flush cycle.
  - Data fields may retain stale values.
- Reset asserted mid-MUL: immediate return to the reset state; the partial product is discarded.

Test Plan:
- ADD: a=0x7FFF, opB=0x0001, out_ready=1 → next cycle out_valid=1, out_result=0x8000, out_neg=1, out_zero=0.
- BEQZ: a=0, imm=0xFFFC, pc_next=0x0010 → out_take_pc=1, out_pc_target=0x000C, out_result=0x0010. Repeat with a=5 → take=0, target=0x0010.
- MUL: a=0x0123, b=0x0011, use_imm=0 → busy for 16 cycles, in_ready=0 throughout, then out_result=0x1353. Then 0xFFFF×0xFFFF → 0x0001.
- Backpressure: out_ready=0 with a result held → in_ready=0; slot stable for 5 cycles. Raise out_ready with a new op valid → slot replaced at the same edge, out_valid remains 1.
- Flush: assert at cycle 8 of a MUL → at that edge busy=0, out_valid=0; next cycle in_ready=1; no product ever appears.
- Async reset: pull rst low mid-cycle during a JR result hold → out_valid, out_take_pc and busy go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/exec_unit_mc.sv
// Pipelined execute stage: single-cycle ALU/branch ops plus an iterative shift-add
// multiplier, all results landing in one valid/ready output slot with flush.
module exec_unit_mc #(
  parameter int WIDTH    = 16,
  parameter int MUL_STEP = 1,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    imm,
  input  logic                use_imm,
  input  logic [WIDTH-1:0]    pc_next,
  input  logic [1:0]          wr_sel,
  input  logic [REG_BITS-1:0] rd0,
  input  logic [REG_BITS-1:0] rd1,
  input  logic [REG_BITS-1:0] rd2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic [REG_BITS-1:0] out_wreg,
  output logic                out_take_pc,
  output logic [WIDTH-1:0]    out_pc_target,
  output logic                out_zero,
  output logic                out_neg,
  output logic                busy
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd3,
                         OP_SLL = 4'd4, OP_SRL = 4'd5, OP_ROL = 4'd6, OP_MUL = 4'd7,
                         OP_BEQZ = 4'd8, OP_BNEZ = 4'd9, OP_BLTZ = 4'd10, OP_BGEZ = 4'd11,
                         OP_J = 4'd12, OP_JR = 4'd13, OP_SLT = 4'd14, OP_PASS = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_result_q, out_result_d;
  logic [REG_BITS-1:0] out_wreg_q, out_wreg_d;
  logic                out_take_pc_q, out_take_pc_d;
  logic [WIDTH-1:0]    out_pc_target_q, out_pc_target_d;

  logic [WIDTH-1:0]    opb;
  logic [SHW-1:0]      sh;
  logic [WIDTH-1:0]    alu_res;
  logic [REG_BITS-1:0] wreg_sel;
  logic                take;
  logic [WIDTH-1:0]    target;
  logic [WIDTH-1:0]    step_acc;
  logic                accept;

  assign opb      = use_imm ? imm : b;
  assign sh       = opb[SHW-1:0];
  assign in_ready = (state_q == S_IDLE) & ~flush & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + opb;
      OP_SUB:  alu_res = a - opb;
      OP_AND:  alu_res = a & opb;
      OP_XOR:  alu_res = a ^ opb;
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      // A zero amount shifts right by WIDTH, which yields zero, so no special case.
      OP_ROL:  alu_res = (a << sh) | (a >> (WIDTH - sh));
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(opb))};
      OP_PASS: alu_res = opb;
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_J, OP_JR: alu_res = pc_next;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wreg_sel = '1;
    case (wr_sel)
      2'b00:   wreg_sel = rd0;
      2'b01:   wreg_sel = rd1;
      2'b10:   wreg_sel = rd2;
      default: wreg_sel = '1;
    endcase
  end

  always_comb begin
    take   = 1'b0;
    target = pc_next;
    case (op)
      OP_BEQZ: take = (a == '0);
      OP_BNEZ: take = (a != '0);
      OP_BLTZ: take = a[WIDTH-1];
      OP_BGEZ: take = ~a[WIDTH-1];
      OP_J:    take = 1'b1;
      OP_JR:   take = 1'b1;
      default: take = 1'b0;
    endcase
    if (take) target = (op == OP_JR) ? (a + imm) : (pc_next + imm);
  end

  always_comb begin
    step_acc = acc_q;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) step_acc = step_acc + (mcand_q << i);
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mcand_d         = mcand_q;
    mplier_d        = mplier_q;
    acc_d           = acc_q;
    out_valid_d     = out_valid_q & ~out_ready;
    out_result_d    = out_result_q;
    out_wreg_d      = out_wreg_q;
    out_take_pc_d   = out_take_pc_q;
    out_pc_target_d = out_pc_target_q;

    if (flush) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      out_valid_d   = 1'b0;
      out_take_pc_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            out_wreg_d = wreg_sel;
            if (op == OP_MUL) begin
              // Slot is empty or draining this edge, so its fields can be preloaded.
              mcand_d         = a;
              mplier_d        = opb;
              acc_d           = '0;
              cnt_d           = '0;
              out_take_pc_d   = 1'b0;
              out_pc_target_d = pc_next;
              state_d         = S_MUL;
            end else begin
              out_result_d    = alu_res;
              out_take_pc_d   = take;
              out_pc_target_d = target;
              out_valid_d     = 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_d    = step_acc;
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(STEPS - 1)) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (~out_valid_q | out_ready) begin
            out_result_d  = acc_q;
            out_take_pc_d = 1'b0;
            out_valid_d   = 1'b1;
            state_d       = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      mcand_q         <= '0;
      mplier_q        <= '0;
      acc_q           <= '0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_wreg_q      <= '0;
      out_take_pc_q   <= 1'b0;
      out_pc_target_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      acc_q           <= acc_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_wreg_q      <= out_wreg_d;
      out_take_pc_q   <= out_take_pc_d;
      out_pc_target_q <= out_pc_target_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_wreg      = out_wreg_q;
  assign out_take_pc   = out_take_pc_q;
  assign out_pc_target = out_pc_target_q;
  assign busy          = (state_q == S_MUL);
  // Flags are qualified by out_valid so an empty slot (including reset) reads all-zero.
  assign out_zero      = out_valid_q & (out_result_q == '0);
  assign out_neg       = out_valid_q & out_result_q[WIDTH-1];

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: table of single-cycle ops plus hand-written
// multiplier, backpressure, flush and asynchronous reset sequences.
module tb_exec_unit_mc;
  localparam int W  = 16;
  localparam int RB = 3;

  logic          clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, use_imm = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_take_pc, out_zero, out_neg, busy;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0, imm = '0, pc_next = '0;
  logic [1:0]    wr_sel = '0;
  logic [RB-1:0] rd0 = 3'd1, rd1 = 3'd2, rd2 = 3'd5;
  logic [RB-1:0] out_wreg;
  logic [W-1:0]  out_result, out_pc_target;

  int errors = 0;
  int checks = 0;

  exec_unit_mc #(.WIDTH(W), .MUL_STEP(1), .REG_BITS(RB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .imm(imm), .use_imm(use_imm), .pc_next(pc_next),
    .wr_sel(wr_sel), .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wreg(out_wreg), .out_take_pc(out_take_pc), .out_pc_target(out_pc_target),
    .out_zero(out_zero), .out_neg(out_neg), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a, b, imm;
    logic          ui;
    logic [W-1:0]  pc;
    logic [1:0]    ws;
    logic [W-1:0]  res;
    logic          take;
    logic [W-1:0]  tgt;
    logic [RB-1:0] wreg;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] va, vb, vi,
                              input logic u, input logic [W-1:0] pc, input logic [1:0] ws,
                              input logic [W-1:0] res, input logic tk, input logic [W-1:0] tg);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.imm = vi; v.ui = u; v.pc = pc; v.ws = ws;
    v.res = res; v.take = tk; v.tgt = tg;
    case (ws)
      2'd0: v.wreg = 3'd1;
      2'd1: v.wreg = 3'd2;
      2'd2: v.wreg = 3'd5;
      default: v.wreg = 3'd7;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] va, vb, vi,
                       input logic u, input logic [W-1:0] pc, input logic [1:0] ws);
    op = o; a = va; b = vb; imm = vi; use_imm = u; pc_next = pc; wr_sel = ws;
    in_valid = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_mul(input string name, input logic [W-1:0] va, vb, vi, input logic u,
                         input logic [W-1:0] exp);
    int c;
    out_ready = 1'b1;
    drive(4'd7, va, vb, vi, u, 16'h0300, 2'd2);
    step();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 40) begin
      chk({name, "_busy"}, busy, (c < 16));
      chk({name, "_in_ready"}, in_ready, 0);
      @(negedge clk);
      c++;
    end
    chk({name, "_latency"}, c, 17);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_wreg"}, out_wreg, 3'd5);
    chk({name, "_take"}, out_take_pc, 0);
    $display("mul %s: cycles=%0d result=%h", name, c, out_result);
  endtask

  initial begin
    int seen;
    vecs[0]  = mk(4'd0,  16'h7FFF, 16'h0001, 16'h0000, 0, 16'h0100, 2'd0, 16'h8000, 0, 16'h0100);
    vecs[1]  = mk(4'd1,  16'h0005, 16'h1234, 16'h0005, 1, 16'h0100, 2'd1, 16'h0000, 0, 16'h0100);
    vecs[2]  = mk(4'd2,  16'hF0F0, 16'h3C3C, 16'h0000, 0, 16'h0100, 2'd2, 16'h3030, 0, 16'h0100);
    vecs[3]  = mk(4'd3,  16'hF0F0, 16'h3C3C, 16'h0000, 0, 16'h0100, 2'd3, 16'hCCCC, 0, 16'h0100);
    vecs[4]  = mk(4'd4,  16'h0003, 16'h0000, 16'h0014, 1, 16'h0100, 2'd0, 16'h0030, 0, 16'h0100);
    vecs[5]  = mk(4'd5,  16'h8000, 16'h000F, 16'h0000, 0, 16'h0100, 2'd0, 16'h0001, 0, 16'h0100);
    vecs[6]  = mk(4'd6,  16'h8001, 16'h0004, 16'h0000, 0, 16'h0100, 2'd0, 16'h0018, 0, 16'h0100);
    vecs[7]  = mk(4'd6,  16'h1234, 16'h0010, 16'h0000, 0, 16'h0100, 2'd0, 16'h1234, 0, 16'h0100);
    vecs[8]  = mk(4'd14, 16'hFFFF, 16'h0001, 16'h0000, 0, 16'h0100, 2'd1, 16'h0001, 0, 16'h0100);
    vecs[9]  = mk(4'd14, 16'h0001, 16'hFFFF, 16'h0000, 0, 16'h0100, 2'd1, 16'h0000, 0, 16'h0100);
    vecs[10] = mk(4'd15, 16'h0000, 16'h1111, 16'hABCD, 1, 16'h0100, 2'd3, 16'hABCD, 0, 16'h0100);
    vecs[11] = mk(4'd8,  16'h0000, 16'h0000, 16'hFFFC, 0, 16'h0010, 2'd0, 16'h0010, 1, 16'h000C);
    vecs[12] = mk(4'd8,  16'h0005, 16'h0000, 16'hFFFC, 0, 16'h0010, 2'd0, 16'h0010, 0, 16'h0010);
    vecs[13] = mk(4'd9,  16'h0005, 16'h0000, 16'h0020, 0, 16'h0100, 2'd0, 16'h0100, 1, 16'h0120);
    vecs[14] = mk(4'd10, 16'h8000, 16'h0000, 16'h0004, 0, 16'h0040, 2'd0, 16'h0040, 1, 16'h0044);
    vecs[15] = mk(4'd11, 16'h8000, 16'h0000, 16'h0004, 0, 16'h0040, 2'd0, 16'h0040, 0, 16'h0040);
    vecs[16] = mk(4'd12, 16'h0000, 16'h0000, 16'h0100, 0, 16'h0200, 2'd3, 16'h0200, 1, 16'h0300);
    vecs[17] = mk(4'd13, 16'h1000, 16'h0000, 16'h0008, 0, 16'h0200, 2'd3, 16'h0200, 1, 16'h1008);
    vecs[18] = mk(4'd1,  16'h0000, 16'h0001, 16'h0000, 0, 16'h0100, 2'd2, 16'hFFFF, 0, 16'h0100);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_take", out_take_pc, 0);
    chk("rst_result", out_result, 0);
    chk("rst_target", out_pc_target, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_neg", out_neg, 0);
    chk("rst_wreg", out_wreg, 0);
    rst = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 1);

    // Table-driven single-cycle ops, back to back with out_ready high
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].ui, vecs[i].pc, vecs[i].ws);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      step();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d_take", i), out_take_pc, vecs[i].take);
      chk($sformatf("v%0d_target", i), out_pc_target, vecs[i].tgt);
      chk($sformatf("v%0d_wreg", i), out_wreg, vecs[i].wreg);
      chk($sformatf("v%0d_zero", i), out_zero, (vecs[i].res == '0));
      chk($sformatf("v%0d_neg", i), out_neg, vecs[i].res[W-1]);
      $display("vec %0d: op=%0d a=%h opb=%h -> result=%h take=%0d target=%h",
               i, vecs[i].op, vecs[i].a, (vecs[i].ui ? vecs[i].imm : vecs[i].b),
               out_result, out_take_pc, out_pc_target);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);

    // Multiplier
    run_mul("mul_a", 16'h0123, 16'h0011, 16'h0000, 0, 16'h1353);
    run_mul("mul_b", 16'h0000, 16'h0000, 16'hFFFF, 1, 16'h0000);
    run_mul("mul_c", 16'hFFFF, 16'hFFFF, 16'h0000, 0, 16'h0001);
    step();

    // Backpressure: held slot, then drain and replace on the same edge
    out_ready = 1'b0;
    drive(4'd0, 16'h0001, 16'h0002, 16'h0000, 0, 16'h0100, 2'd0);
    step();
    chk("bp_valid", out_valid, 1);
    chk("bp_result", out_result, 16'h0003);
    drive(4'd3, 16'h00FF, 16'h0F0F, 16'h0000, 0, 16'h0100, 2'd2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 16'h0003);
      chk("bp_hold_wreg", out_wreg, 3'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    step();
    chk("bp_replace_valid", out_valid, 1);
    chk("bp_replace_result", out_result, 16'h0FF0);
    chk("bp_replace_wreg", out_wreg, 3'd5);
    $display("backpressure: replaced result=%h valid=%0d", out_result, out_valid);
    in_valid = 1'b0;
    step();
    chk("bp_drained", out_valid, 0);

    // Flush of a held slot with a new op offered: nothing accepted
    out_ready = 1'b0;
    drive(4'd0, 16'h0002, 16'h0002, 16'h0000, 0, 16'h0100, 2'd0);
    step();
    chk("fl_slot_valid", out_valid, 1);
    drive(4'd0, 16'h0009, 16'h0001, 16'h0000, 0, 16'h0100, 2'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    step();
    chk("fl_slot_cleared", out_valid, 0);
    chk("fl_take_cleared", out_take_pc, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    $display("flush slot: valid=%0d", out_valid);

    // Flush during a multiply
    drive(4'd7, 16'h0003, 16'h0005, 16'h0000, 0, 16'h0100, 2'd0);
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("flmul_busy_before", busy, 1);
    flush = 1'b1;
    drive(4'd0, 16'h0001, 16'h0001, 16'h0000, 0, 16'h0100, 2'd0);
    #1;
    chk("flmul_in_ready_during", in_ready, 0);
    step();
    chk("flmul_busy_after", busy, 0);
    chk("flmul_valid_after", out_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flmul_in_ready_next", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (out_valid) seen++;
    end
    chk("flmul_no_product", seen, 0);
    $display("flush mul: product cycles seen=%0d", seen);

    // Asynchronous reset while a JR result is held
    out_ready = 1'b0;
    drive(4'd13, 16'h1000, 16'h0000, 16'h0008, 0, 16'h0200, 2'd3);
    step();
    in_valid = 1'b0;
    chk("ar_jr_valid", out_valid, 1);
    chk("ar_jr_take", out_take_pc, 1);
    chk("ar_jr_target", out_pc_target, 16'h1008);
    chk("ar_jr_wreg", out_wreg, 3'd7);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_take", out_take_pc, 0);
    chk("ar_busy", busy, 0);
    chk("ar_target", out_pc_target, 0);
    chk("ar_result", out_result, 0);
    $display("async reset: valid=%0d take=%0d", out_valid, out_take_pc);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;

    // Asynchronous reset mid-multiply discards the product
    drive(4'd7, 16'h0007, 16'h0009, 16'h0000, 0, 16'h0100, 2'd0);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("armul_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("armul_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (out_valid) seen++;
    end
    chk("armul_no_product", seen, 0);
    chk("armul_in_ready", in_ready, 1);
    $display("reset mul: product cycles seen=%0d", seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
